// File: rtl/ps2_scan_code_capture_if.sv
// Bus bundle for ps2_scan_code_capture: the raw PS/2 pins going in and the
// captured byte, status pulses and display history coming out.
// master = pin/stimulus side, slave = capture block.
interface ps2_scan_code_capture_if #(
   parameter int unsigned HISTORY_BYTES = 3
);
   localparam int unsigned HW = 8 * HISTORY_BYTES;

   logic          ps2_clk_in;
   logic          ps2_dat_in;
   logic [7:0]    byte_data;
   logic          byte_valid;
   logic          frame_error;
   logic [7:0]    rx_count;
   logic [HW-1:0] hex_digits;

   modport master (
      output ps2_clk_in,
      output ps2_dat_in,
      input  byte_data,
      input  byte_valid,
      input  frame_error,
      input  rx_count,
      input  hex_digits
   );

   modport slave (
      input  ps2_clk_in,
      input  ps2_dat_in,
      output byte_data,
      output byte_valid,
      output frame_error,
      output rx_count,
      output hex_digits
   );
endinterface

// File: rtl/ps2_scan_code_capture.sv
// PS/2 device-to-host receiver: synchronizes the raw pins, detects falling
// edges of the PS/2 clock, assembles start/8 data/odd parity/stop frames and
// keeps a byte history packed as nibbles for the HEX display converters.
// Optional macro PS2_BREAK_FILTER_EN: keeps 0xF0 break prefixes and the byte
// following them out of the display history.
module ps2_scan_code_capture #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned HISTORY_BYTES  = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   ps2_scan_code_capture_if.slave  bus
);

   localparam int unsigned HW    = 8 * HISTORY_BYTES;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_prev_q;

   logic [1:0]       state_q,       state_d;
   logic [2:0]       bit_cnt_q,     bit_cnt_d;
   logic [7:0]       shift_q,       shift_d;
   logic             parity_q,      parity_d;
   logic [TMO_W-1:0] tmo_q,         tmo_d;
   logic [7:0]       byte_data_q,   byte_data_d;
   logic             byte_valid_q,  byte_valid_d;
   logic             frame_error_q, frame_error_d;
   logic [7:0]       rx_count_q,    rx_count_d;
   logic [HW-1:0]    hex_q,         hex_d;
   logic [HW-1:0]    hex_shift_c;
   logic             fall_c;
   logic             dat_c;

`ifdef PS2_BREAK_FILTER_EN
   logic             brk_q, brk_d;
`endif

   assign fall_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign dat_c  = dat_sync_q[SYNC_STAGES-1];

   // History with the assembled byte pushed in as the newest entry
   generate
      if (HISTORY_BYTES == 1) begin : g_hist_one
         assign hex_shift_c = shift_q;
      end else begin : g_hist_many
         assign hex_shift_c = {hex_q[HW-9:0], shift_q};
      end
   endgenerate

   // Pin synchronizers and PS/2 clock edge-detect register, idle-high on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk_in};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat_in};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   // Next-state and output logic for the frame receiver
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      parity_d      = parity_q;
      tmo_d         = tmo_q;
      byte_data_d   = byte_data_q;
      byte_valid_d  = 1'b0;
      frame_error_d = 1'b0;
      rx_count_d    = rx_count_q;
      hex_d         = hex_q;
`ifdef PS2_BREAK_FILTER_EN
      brk_d         = brk_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (fall_c && !dat_c) begin
               state_d   = ST_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (fall_c) begin
               shift_d   = {dat_c, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (fall_c) begin
               parity_d = dat_c;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall_c) begin
               state_d = ST_IDLE;
               if (dat_c && (^{shift_q, parity_q})) begin
                  byte_data_d  = shift_q;
                  byte_valid_d = 1'b1;
                  rx_count_d   = rx_count_q + 8'd1;
`ifdef PS2_BREAK_FILTER_EN
                  // Break prefix and its key code stay off the display
                  if (brk_q) begin
                     brk_d = 1'b0;
                  end else if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else begin
                     hex_d = hex_shift_c;
                  end
`else
                  hex_d = hex_shift_c;
`endif
               end else begin
                  frame_error_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Inter-edge watchdog; a falling edge always takes priority over expiry
      if (state_q == ST_IDLE) begin
         tmo_d = '0;
      end else if (fall_c) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         tmo_d         = '0;
         state_d       = ST_IDLE;
         frame_error_d = 1'b1;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   // Receiver state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         parity_q      <= 1'b0;
         tmo_q         <= '0;
         byte_data_q   <= '0;
         byte_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         rx_count_q    <= '0;
         hex_q         <= '0;
`ifdef PS2_BREAK_FILTER_EN
         brk_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         parity_q      <= parity_d;
         tmo_q         <= tmo_d;
         byte_data_q   <= byte_data_d;
         byte_valid_q  <= byte_valid_d;
         frame_error_q <= frame_error_d;
         rx_count_q    <= rx_count_d;
         hex_q         <= hex_d;
`ifdef PS2_BREAK_FILTER_EN
         brk_q         <= brk_d;
`endif
      end
   end

   assign bus.byte_data   = byte_data_q;
   assign bus.byte_valid  = byte_valid_q;
   assign bus.frame_error = frame_error_q;
   assign bus.rx_count    = rx_count_q;
   assign bus.hex_digits  = hex_q;

endmodule
